ula_nibble_serial: RTL and testbench
====================================

# ula_nibble_serial

Nibble-serial, parametrised successor to the 4-bit 74181-style ULA.
- Processes a WIDTH-bit operand pair one 4-bit slice per clock, LSB slice first, through a single 74181-function slice.
- Carry is chained between slices in a register.
- Sits behind a valid/ready handshake, so datapaths wider than 4 bits reuse one slice instead of cascading combinational units.

## Interface
Parameters:
- WIDTH, 16, operand/result width; must be a multiple of 4 and ≥4. Violation is an elaboration `$error`.
- NSLICE (localparam), WIDTH/4, number of slice cycles.

Ports:
- clk  in  1  clock, rising-edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- in_valid  in  1  operands valid.
- in_ready  out  1  block can accept operands.
- a, b  in  WIDTH  operands.
- s  in  4  function select.
- m  in  1  0 = arithmetic, 1 = logic.
- c_in  in  1  carry-in, active-high, applies to slice 0 only.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- f  out  WIDTH  result.
- c_out  out  1  carry out of the top slice; 0 when m=1.
- a_eq_b  out  1  `&f`, as on the 74181.
- zero  out  1  f == 0.
- p, g  out  1  group propagate/generate. Present only with ULA_PG_EN.

## Operation
- Functions use the 74181 active-high table. Each arithmetic result is the base expression plus the carry.
- Arithmetic mode (m=0), by s value 0 to F:
  - 0: A
  - 1: A|B
  - 2: A|~B
  - 3: −1
  - 4: A+(A&~B)
  - 5: (A|B)+(A&~B)
  - 6: A−B−1
  - 7: (A&~B)−1
  - 8: A+(A&B)
  - 9: A+B
  - A: (A|~B)+(A&B)
  - B: (A&B)−1
  - C: A+A
  - D: (A|B)+A
  - E: (A|~B)+A
  - F: A−1
- Logic mode (m=1), by s value 0 to F:
  - 0: ~A
  - 1: ~(A|B)
  - 2: ~A&B
  - 3: 0
  - 4: ~(A&B)
  - 5: ~B
  - 6: A^B
  - 7: A&~B
  - 8: ~A|B
  - 9: ~(A^B)
  - A: B
  - B: A&B
  - C: all-ones
  - D: A|~B
  - E: A|B
  - F: A
  - No carry is involved in logic mode.
- Arithmetic is modulo 2^WIDTH. The carry out of slice k is the carry into slice k+1.
- FSM states:
  - IDLE: in_ready=1. On in_valid, capture a, b, s, m, c_in into registers, clear the slice counter, go to RUN.
  - RUN: each cycle computes slice `cnt`, writes `f[4cnt+3:4cnt]` and updates the carry register. When cnt == NSLICE−1, go to DONE.
  - DONE: out_valid=1. On out_ready, go to IDLE.
- Inputs are ignored outside the IDLE accept cycle; captured operands are immune to later input changes.
- f, c_out, a_eq_b, zero (and p, g) are registered. They are valid and stable whenever out_valid=1.
- Reset (rst_n low, at any time including mid-RUN) aborts the operation. State returns to IDLE; partial results are discarded.
- Reset values: in_ready=1, out_valid=0, f=0, c_out=0, a_eq_b=0, zero=0, p=0, g=0.

## Timing
- Accept edge E0 (in_valid & in_ready). in_ready drops after E0.
- Slice k is registered at edge E0+k+1. out_valid rises at edge E0+NSLICE, giving latency NSLICE cycles (4 for WIDTH=16).
- Results hold while out_valid=1 and out_ready=0 (backpressure, unbounded).
- Result accepted at edge E1: out_valid falls and in_ready rises after E1. Minimum issue interval is NSLICE+2 cycles.
- in_ready and out_valid are never both 1.

## Configuration
- ULA_PG_EN defined:
  - Ports p and g exist.
  - Per slice, g_s is the carry-out with slice carry-in=0, and p_s = carry-out(cin=1) & ~g_s.
  - Accumulated LSB→MSB: g ← g_s | (p_s & g), p ← p & p_s (p starts at 1).
  - Both are forced to 0 when m=1 and are registered with f.
- ULA_PG_EN undefined: ports p and g are absent, along with all their logic.

## Test plan
- Add with carry propagation: m=0, s=1001, a=16'h00FF, b=16'h0001, c_in=0.
  - Expect f=16'h0100, c_out=0, zero=0.
  - out_valid exactly 4 cycles after accept.
- Full-width wrap: m=0, s=1001, a=16'hFFFF, b=16'h0001, c_in=0.
  - Expect f=16'h0000, c_out=1, zero=1, a_eq_b=0.
- Compare via A−B−1: m=0, s=0110, a=b=16'h1234.
  - c_in=0: expect f=16'hFFFF, a_eq_b=1, c_out=0.
  - c_in=1: expect f=0, c_out=1.
- Logic XOR and backpressure: m=1, s=0110, a=16'hA5A5, b=16'hFFFF, out_ready held 0 for 3 cycles.
  - Expect f=16'h5A5A, c_out=0, stable for those cycles, in_ready=0.
  - in_ready=1 the cycle after out_ready=1.
- Reset mid-RUN: assert rst_n=0 during slice 2.
  - All outputs take their reset values immediately.
  - A new op accepted after release completes correctly.
- With ULA_PG_EN, m=0, s=1001:
  - a=16'h5555, b=16'hAAAA: expect p=1, g=0.
  - a=b=16'hFFFF: expect p=0, g=1.

Source files
------------

// File: rtl/ula_nibble_serial.sv
// ---------------------------------------------------------------------------
// ula_nibble_serial
//
// Nibble-serial 74181-style arithmetic/logic unit. A WIDTH-bit operand pair
// is processed one 4-bit slice per clock, least-significant slice first,
// through a single 74181-function slice. The slice carry is chained between
// cycles in a register. Operands enter and results leave through
// valid/ready handshakes.
//
// Parameters
//   WIDTH      operand/result width, multiple of 4 and >= 4 (default 16)
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset; aborts any operation in flight
//   in_valid   operands valid            in_ready  block can accept operands
//   a, b       WIDTH-bit operands
//   s          4-bit function select     m         0 = arithmetic, 1 = logic
//   c_in       active-high carry into slice 0 (arithmetic only)
//   out_valid  result valid              out_ready consumer accepts result
//   f          WIDTH-bit result
//   c_out      carry out of the top slice (0 in logic mode)
//   a_eq_b     &f, as on the 74181
//   zero       f == 0
//   p, g       group propagate/generate (only when ULA_PG_EN is defined)
//
// Optional feature macro: ULA_PG_EN adds the p/g outputs and their logic.
// ---------------------------------------------------------------------------
module ula_nibble_serial #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       s,
    input  logic             m,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] f,
    output logic             c_out,
    output logic             a_eq_b,
    output logic             zero
`ifdef ULA_PG_EN
    ,
    output logic             p,
    output logic             g
`endif
);

    localparam int NSLICE = WIDTH / 4;
    localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    generate
        if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_width_check
            $error("ula_nibble_serial: WIDTH (%0d) must be a multiple of 4 and >= 4", WIDTH);
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Slice functions
    // -----------------------------------------------------------------------

    // Arithmetic mode: each function is lhs + rhs + carry. The "-1" terms of
    // the 74181 table are an all-ones addend; replicating 4'hF in every slice
    // makes the chained result equal to the full-width all-ones addend.
    function automatic logic [7:0] arith_terms(input logic [3:0] x,
                                               input logic [3:0] y,
                                               input logic [3:0] sel);
        logic [3:0] lhs;
        logic [3:0] rhs;
        lhs = x;
        rhs = 4'h0;
        case (sel)
            4'h0: begin lhs = x;        rhs = 4'h0;    end
            4'h1: begin lhs = x | y;    rhs = 4'h0;    end
            4'h2: begin lhs = x | ~y;   rhs = 4'h0;    end
            4'h3: begin lhs = 4'h0;     rhs = 4'hF;    end
            4'h4: begin lhs = x;        rhs = x & ~y;  end
            4'h5: begin lhs = x | y;    rhs = x & ~y;  end
            4'h6: begin lhs = x;        rhs = ~y;      end
            4'h7: begin lhs = x & ~y;   rhs = 4'hF;    end
            4'h8: begin lhs = x;        rhs = x & y;   end
            4'h9: begin lhs = x;        rhs = y;       end
            4'hA: begin lhs = x | ~y;   rhs = x & y;   end
            4'hB: begin lhs = x & y;    rhs = 4'hF;    end
            4'hC: begin lhs = x;        rhs = x;       end
            4'hD: begin lhs = x | y;    rhs = x;       end
            4'hE: begin lhs = x | ~y;   rhs = x;       end
            default: begin lhs = x;     rhs = 4'hF;    end
        endcase
        return {lhs, rhs};
    endfunction

    function automatic logic [3:0] logic_fn(input logic [3:0] x,
                                            input logic [3:0] y,
                                            input logic [3:0] sel);
        logic [3:0] r;
        r = 4'h0;
        case (sel)
            4'h0: r = ~x;
            4'h1: r = ~(x | y);
            4'h2: r = ~x & y;
            4'h3: r = 4'h0;
            4'h4: r = ~(x & y);
            4'h5: r = ~y;
            4'h6: r = x ^ y;
            4'h7: r = x & ~y;
            4'h8: r = ~x | y;
            4'h9: r = ~(x ^ y);
            4'hA: r = y;
            4'hB: r = x & y;
            4'hC: r = 4'hF;
            4'hD: r = x | ~y;
            4'hE: r = x | y;
            default: r = x;
        endcase
        return r;
    endfunction

    function automatic logic [4:0] add4(input logic [3:0] x,
                                        input logic [3:0] y,
                                        input logic       ci);
        return {1'b0, x} + {1'b0, y} + {4'b0000, ci};
    endfunction

`ifdef ULA_PG_EN
    function automatic logic carry4(input logic [3:0] x,
                                    input logic [3:0] y,
                                    input logic       ci);
        logic [4:0] t;
        t = add4(x, y, ci);
        return t[4];
    endfunction
`endif

    // -----------------------------------------------------------------------
    // Control state
    // -----------------------------------------------------------------------
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             accept;
    logic             last_slice;

    // Captured operands (datapath, no reset)
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [3:0]       s_q;
    logic             m_q;
    logic             carry_q;

    // Slice datapath
    logic [CNT_W+1:0] base;
    logic [3:0]       a_sl;
    logic [3:0]       b_sl;
    logic [7:0]       terms;
    logic [4:0]       sum;
    logic [3:0]       slice_f;
    logic             slice_co;
    logic [WIDTH-1:0] f_next;

`ifdef ULA_PG_EN
    logic             p_acc;
    logic             g_acc;
    logic             g_s;
    logic             p_s;
    logic             p_next;
    logic             g_next;
`endif

    assign accept     = in_valid & in_ready;
    assign last_slice = (state_q == RUN) && (cnt_q == CNT_W'(NSLICE - 1));

    // -----------------------------------------------------------------------
    // FSM
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = RUN;
            end
            RUN: begin
                if (last_slice) state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Slice evaluation for slice cnt_q
    // -----------------------------------------------------------------------
    always_comb begin
        base     = {cnt_q, 2'b00};
        a_sl     = a_q[base +: 4];
        b_sl     = b_q[base +: 4];
        terms    = arith_terms(a_sl, b_sl, s_q);
        sum      = add4(terms[7:4], terms[3:0], carry_q);
        slice_f  = m_q ? logic_fn(a_sl, b_sl, s_q) : sum[3:0];
        slice_co = m_q ? 1'b0 : sum[4];
        f_next             = f;
        f_next[base +: 4]  = slice_f;
    end

`ifdef ULA_PG_EN
    // Slice generate: carries even with no carry in. Slice propagate: carries
    // only because of the carry in, i.e. the slice sum is exactly 4'hF.
    always_comb begin
        g_s    = carry4(terms[7:4], terms[3:0], 1'b0);
        p_s    = carry4(terms[7:4], terms[3:0], 1'b1) & ~g_s;
        g_next = g_s | (p_s & g_acc);
        p_next = p_acc & p_s;
    end
`endif

    // -----------------------------------------------------------------------
    // Operand capture and inter-slice carry
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (accept) begin
            a_q     <= a;
            b_q     <= b;
            s_q     <= s;
            m_q     <= m;
            carry_q <= c_in;
`ifdef ULA_PG_EN
            p_acc   <= 1'b1;
            g_acc   <= 1'b0;
`endif
        end else if (state_q == RUN) begin
            carry_q <= slice_co;
`ifdef ULA_PG_EN
            p_acc   <= p_next;
            g_acc   <= g_next;
`endif
        end
    end

    // -----------------------------------------------------------------------
    // Slice counter and registered results
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            f      <= '0;
            c_out  <= 1'b0;
            a_eq_b <= 1'b0;
            zero   <= 1'b0;
`ifdef ULA_PG_EN
            p      <= 1'b0;
            g      <= 1'b0;
`endif
        end else if (accept) begin
            cnt_q <= '0;
        end else if (state_q == RUN) begin
            cnt_q <= cnt_q + CNT_W'(1);
            f     <= f_next;
            // Flags are taken from f_next so they include the top slice.
            if (last_slice) begin
                c_out  <= slice_co;
                a_eq_b <= &f_next;
                zero   <= ~|f_next;
`ifdef ULA_PG_EN
                p      <= p_next & ~m_q;
                g      <= g_next & ~m_q;
`endif
            end
        end
    end

endmodule

// File: tb/tb_ula_nibble_serial.sv
module tb_ula_nibble_serial;

    localparam int W = 16;

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b1;
    logic         in_valid  = 1'b0;
    logic         in_ready;
    logic [W-1:0] a         = '0;
    logic [W-1:0] b         = '0;
    logic [3:0]   s         = 4'h0;
    logic         m         = 1'b0;
    logic         c_in      = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] f;
    logic         c_out;
    logic         a_eq_b;
    logic         zero;
`ifdef ULA_PG_EN
    logic         p;
    logic         g;
`endif

    always #5 clk = ~clk;

    ula_nibble_serial #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .s         (s),
        .m         (m),
        .c_in      (c_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .f         (f),
        .c_out     (c_out),
        .a_eq_b    (a_eq_b),
        .zero      (zero)
`ifdef ULA_PG_EN
        ,
        .p         (p),
        .g         (g)
`endif
    );

    typedef struct packed {
        logic [15:0] f;
        logic        c;
        logic        eq;
        logic        z;
        logic        chk_pg;
        logic        p;
        logic        g;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic exp_t mk(input logic [15:0] ef, input logic ec, input logic eeq, input logic ez);
        exp_t e;
        e = '{f: ef, c: ec, eq: eeq, z: ez, chk_pg: 1'b0, p: 1'b0, g: 1'b0};
        return e;
    endfunction

    function automatic exp_t mkpg(input logic [15:0] ef, input logic ec, input logic eeq, input logic ez,
                                  input logic ep, input logic eg);
        exp_t e;
        e = '{f: ef, c: ec, eq: eeq, z: ez, chk_pg: 1'b1, p: ep, g: eg};
        return e;
    endfunction

    // Full-width reference of the 74181 active-high table.
    function automatic exp_t model(input logic [15:0] ma, input logic [15:0] mb,
                                   input logic [3:0] ms, input logic mm, input logic mc);
        logic [16:0] A, r, ci, all1;
        logic [15:0] lf;
        exp_t        e;
        A    = {1'b0, ma};
        ci   = {16'h0, mc};
        all1 = 17'h0FFFF;
        r    = '0;
        lf   = '0;
        if (mm) begin
            case (ms)
                4'h0: lf = ~ma;          4'h1: lf = ~(ma | mb);
                4'h2: lf = ~ma & mb;     4'h3: lf = 16'h0000;
                4'h4: lf = ~(ma & mb);   4'h5: lf = ~mb;
                4'h6: lf = ma ^ mb;      4'h7: lf = ma & ~mb;
                4'h8: lf = ~ma | mb;     4'h9: lf = ~(ma ^ mb);
                4'hA: lf = mb;           4'hB: lf = ma & mb;
                4'hC: lf = 16'hFFFF;     4'hD: lf = ma | ~mb;
                4'hE: lf = ma | mb;      default: lf = ma;
            endcase
            r = {1'b0, lf};
        end else begin
            case (ms)
                4'h0: r = A + ci;
                4'h1: r = {1'b0, ma | mb} + ci;
                4'h2: r = {1'b0, ma | ~mb} + ci;
                4'h3: r = all1 + ci;
                4'h4: r = A + {1'b0, ma & ~mb} + ci;
                4'h5: r = {1'b0, ma | mb} + {1'b0, ma & ~mb} + ci;
                4'h6: r = A + {1'b0, ~mb} + ci;
                4'h7: r = {1'b0, ma & ~mb} + all1 + ci;
                4'h8: r = A + {1'b0, ma & mb} + ci;
                4'h9: r = A + {1'b0, mb} + ci;
                4'hA: r = {1'b0, ma | ~mb} + {1'b0, ma & mb} + ci;
                4'hB: r = {1'b0, ma & mb} + all1 + ci;
                4'hC: r = A + A + ci;
                4'hD: r = {1'b0, ma | mb} + A + ci;
                4'hE: r = {1'b0, ma | ~mb} + A + ci;
                default: r = A + all1 + ci;
            endcase
        end
        e = mk(r[15:0], r[16], &r[15:0], (r[15:0] == 16'h0000));
        return e;
    endfunction

    // One complete transaction: accept, latency, optional backpressure,
    // scoreboard compare, result handshake.
    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_, input logic [3:0] ts,
                          input logic tm, input logic tc, input int hold, input exp_t e);
        int   lat;
        exp_t want;
        @(negedge clk);
        lat = 0;
        while (!in_ready && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("in_ready_idle", in_ready, 1);
        a = ta; b = tb_; s = ts; m = tm; c_in = tc;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        sb.push_back(e);
        @(posedge clk);
        #1;
        // Scramble inputs: captured operands must not follow them.
        in_valid = 1'b0;
        a = ~ta; b = ~tb_; s = ~ts; m = ~tm; c_in = ~tc;
        lat = 0;
        @(negedge clk);
        check("in_ready_drop", in_ready, 0);
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("latency", lat, 4);
        check("not_both", in_ready, 0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", out_valid, 1);
            check("hold_f", f, e.f);
            check("hold_c_out", c_out, e.c);
            check("hold_in_ready", in_ready, 0);
        end
        check("sb_nonempty", (sb.size() > 0), 1);
        if (sb.size() > 0) begin
            want = sb.pop_front();
            check("f", f, want.f);
            check("c_out", c_out, want.c);
            check("a_eq_b", a_eq_b, want.eq);
            check("zero", zero, want.z);
`ifdef ULA_PG_EN
            if (want.chk_pg) begin
                check("p", p, want.p);
                check("g", g, want.g);
            end
`endif
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("out_valid_fall", out_valid, 0);
        check("in_ready_rise", in_ready, 1);
    endtask

    initial begin
        logic [15:0] ra, rb;
        logic [3:0]  rs;
        logic        rm, rc;

        // Power-on reset
        #1 rst_n = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_f", f, 0);
        check("rst_c_out", c_out, 0);
        check("rst_a_eq_b", a_eq_b, 0);
        check("rst_zero", zero, 0);
`ifdef ULA_PG_EN
        check("rst_p", p, 0);
        check("rst_g", g, 0);
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Add with carry propagation across slices
        run_op(16'h00FF, 16'h0001, 4'h9, 1'b0, 1'b0, 0, mk(16'h0100, 1'b0, 1'b0, 1'b0));
        // Full-width wrap
        run_op(16'hFFFF, 16'h0001, 4'h9, 1'b0, 1'b0, 0, mk(16'h0000, 1'b1, 1'b0, 1'b1));
        // A-B-1 compare, both carry-ins
        run_op(16'h1234, 16'h1234, 4'h6, 1'b0, 1'b0, 0, mk(16'hFFFF, 1'b0, 1'b1, 1'b0));
        run_op(16'h1234, 16'h1234, 4'h6, 1'b0, 1'b1, 0, mk(16'h0000, 1'b1, 1'b0, 1'b1));
        // Logic XOR with 3 cycles of backpressure
        run_op(16'hA5A5, 16'hFFFF, 4'h6, 1'b1, 1'b0, 3, mk(16'h5A5A, 1'b0, 1'b0, 1'b0));
        // Logic mode ignores carry-in
        run_op(16'h0F0F, 16'h1234, 4'hC, 1'b1, 1'b1, 0, mk(16'hFFFF, 1'b0, 1'b1, 1'b0));

        // Reset during slice 2
        @(negedge clk);
        a = 16'h1234; b = 16'h0000; s = 4'hF; m = 1'b1; c_in = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        check("mid_run_busy", in_ready, 0);
        rst_n = 1'b0;
        #1;
        check("abort_in_ready", in_ready, 1);
        check("abort_out_valid", out_valid, 0);
        check("abort_f", f, 0);
        check("abort_c_out", c_out, 0);
        check("abort_a_eq_b", a_eq_b, 0);
        check("abort_zero", zero, 0);
        @(negedge clk);
        rst_n = 1'b1;
        // First op after reset: A-1 with A=0
        run_op(16'h0000, 16'h5A5A, 4'hF, 1'b0, 1'b0, 0, mk(16'hFFFF, 1'b0, 1'b1, 1'b0));

        // Group propagate / generate
        run_op(16'h5555, 16'hAAAA, 4'h9, 1'b0, 1'b0, 0, mkpg(16'hFFFF, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0));
        run_op(16'hFFFF, 16'hFFFF, 4'h9, 1'b0, 1'b0, 0, mkpg(16'hFFFE, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1));
        // Logic mode forces p/g low
        run_op(16'h5555, 16'hAAAA, 4'h9, 1'b1, 1'b0, 0, mkpg(16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));

        // Random operations against the reference table
        for (int i = 0; i < 10; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rs = 4'($urandom_range(0, 15));
            rm = 1'($urandom_range(0, 1));
            rc = 1'($urandom_range(0, 1));
            run_op(ra, rb, rs, rm, rc, i % 2, model(ra, rb, rs, rm, rc));
        end

        check("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
